// File: rtl/wb_timer.sv
// wb_timer: Wishbone-classic slave with a 32-bit up-counter, a compare
// register, an optional 16-bit prescaler and a level interrupt.
//
// Register map (adr_i[1:0]):
//   0 CTRL    [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN, [31:16] PRESCALE
//   1 COUNT   free-running up-counter, advanced on each prescaler tick
//   2 COMPARE match value for COUNT
//   3 STATUS  [0] MATCH, write 1 to clear
//
// Handshake: a transfer is requested on any rising edge where
// cyc_i & stb_i is high and ack_o is low. That same edge performs the
// write (or captures read data into dat_o) and raises ack_o for exactly
// one cycle; the following edge always drops ack_o, so a held strobe is
// served every other cycle. Dropping cyc_i while ack_o is high does not
// undo the transfer that ack_o reports.
module wb_timer #(
  parameter int ADR_W = 30
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic [ADR_W-1:0] adr_i,
  input  logic [3:0]       sel_i,
  input  logic [31:0]      dat_i,
  output logic             ack_o,
  output logic [31:0]      dat_o,
  output logic             irq_o
);

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_COUNT   = 2'd1;
  localparam logic [1:0] ADDR_COMPARE = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  // Register state
  logic        en;
  logic        auto_reload;
  logic        irq_en;
  logic [15:0] prescale;
  logic [31:0] count;
  logic [31:0] compare;
  logic        match;
  logic [15:0] ps;

  // Bus decode
  logic        req;
  logic        wr;
  logic        rd;
  logic [1:0]  reg_addr;
  logic        ctrl_wr;
  logic        count_wr;
  logic        compare_wr;
  logic        status_wr;
  logic [31:0] rd_data;

  // Timer events
  logic        tick;
  logic        hit;

  // Only the low two word-address bits select a register.
  logic        unused_adr;
  assign unused_adr = ^adr_i[ADR_W-1:2];

  assign reg_addr   = adr_i[1:0];
  assign req        = cyc_i & stb_i & ~ack_o;
  assign wr         = req & we_i;
  assign rd         = req & ~we_i;
  assign ctrl_wr    = wr & (reg_addr == ADDR_CTRL);
  assign count_wr   = wr & (reg_addr == ADDR_COUNT);
  assign compare_wr = wr & (reg_addr == ADDR_COMPARE);
  assign status_wr  = wr & (reg_addr == ADDR_STATUS);

  // A tick fires when the prescaler reaches PRESCALE; a hit is a tick that
  // finds COUNT equal to COMPARE.
  assign tick = en & (ps == prescale);
  assign hit  = tick & (count == compare);

  assign irq_o = match & irq_en;

  // Replace only the bytes whose enable is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (cur & ~mask) | (wdat & mask);
  endfunction

  // Read-data mux of the current register contents.
  always_comb begin
    rd_data = 32'd0;
    case (reg_addr)
      ADDR_CTRL:    rd_data = {prescale, 13'd0, irq_en, auto_reload, en};
      ADDR_COUNT:   rd_data = count;
      ADDR_COMPARE: rd_data = compare;
      ADDR_STATUS:  rd_data = {31'd0, match};
      default:      rd_data = 32'd0;
    endcase
  end

  // Acknowledge: one-cycle pulse on the edge that accepts a request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_o <= 1'b0;
    end else begin
      ack_o <= req;
    end
  end

  // Read data register: loaded only when a read is accepted, held otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dat_o <= 32'd0;
    end else if (rd) begin
      dat_o <= rd_data;
    end
  end

  // CTRL: a non-reload hit stops the timer, but a bus write to the EN byte
  // on the same edge overrides that.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en          <= 1'b0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      prescale    <= 16'd0;
    end else begin
      if (hit && !auto_reload) begin
        en <= 1'b0;
      end
      if (ctrl_wr && sel_i[0]) begin
        en          <= dat_i[0];
        auto_reload <= dat_i[1];
        irq_en      <= dat_i[2];
      end
      if (ctrl_wr && sel_i[2]) begin
        prescale[7:0] <= dat_i[23:16];
      end
      if (ctrl_wr && sel_i[3]) begin
        prescale[15:8] <= dat_i[31:24];
      end
    end
  end

  // Prescaler: counts up while enabled and restarts on a tick, while
  // disabled, or whenever CTRL is written.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ps <= 16'd0;
    end else if (!en || ctrl_wr || tick) begin
      ps <= 16'd0;
    end else begin
      ps <= ps + 16'd1;
    end
  end

  // COUNT: a bus write wins over any tick on the same edge. On a hit the
  // counter reloads to zero or holds; otherwise it advances and wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= 32'd0;
    end else if (count_wr) begin
      count <= byte_merge(count, dat_i, sel_i);
    end else if (tick) begin
      if (hit) begin
        if (auto_reload) begin
          count <= 32'd0;
        end
      end else begin
        count <= count + 32'd1;
      end
    end
  end

  // COMPARE: plain byte-writable register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      compare <= 32'd0;
    end else if (compare_wr) begin
      compare <= byte_merge(compare, dat_i, sel_i);
    end
  end

  // MATCH: a hit takes priority over a simultaneous write-1-to-clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      match <= 1'b0;
    end else if (hit) begin
      match <= 1'b1;
    end else if (status_wr && sel_i[0] && dat_i[0]) begin
      match <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer: table-driven register checks, directed timer sequences and a
// randomized bus phase checked against a cycle-level reference model.
module tb_wb_timer;

  localparam int ADR_W = 30;

  logic             clk = 1'b0;
  logic             rst;
  logic             cyc;
  logic             stb;
  logic             we;
  logic [ADR_W-1:0] adr;
  logic [3:0]       sel;
  logic [31:0]      dat_w;
  logic             ack;
  logic [31:0]      dat_r;
  logic             irq;

  int n_checks = 0;
  int n_pass   = 0;

  wb_timer #(.ADR_W(ADR_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .cyc_i (cyc),
    .stb_i (stb),
    .we_i  (we),
    .adr_i (adr),
    .sel_i (sel),
    .dat_i (dat_w),
    .ack_o (ack),
    .dat_o (dat_r),
    .irq_o (irq)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Registers are kept as their 32-bit bus images; each rising edge is
  // evaluated from the register-map rules.
  logic [31:0] m_ctrl, m_count, m_compare, m_dat;
  logic [15:0] m_ps;
  logic        m_match, m_ack, m_ack_rd;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] apply_bytes(input logic [31:0] cur,
                                              input logic [31:0] wd,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic model_step();
    logic        req, m_en, m_auto, tick, hit, n_match;
    logic [1:0]  ra;
    logic [31:0] rdv, n_ctrl, n_count, n_cmp;
    logic [15:0] n_ps;
    if (rst) begin
      m_ctrl = '0; m_count = '0; m_compare = '0; m_dat = '0;
      m_ps = '0; m_match = 1'b0; m_ack = 1'b0; m_ack_rd = 1'b0;
      exp_q.delete();
      return;
    end
    req    = cyc & stb & ~m_ack;
    ra     = adr[1:0];
    m_en   = m_ctrl[0];
    m_auto = m_ctrl[1];
    case (ra)
      2'd0: rdv = m_ctrl;
      2'd1: rdv = m_count;
      2'd2: rdv = m_compare;
      default: rdv = {31'd0, m_match};
    endcase
    tick    = m_en && (m_ps == m_ctrl[31:16]);
    hit     = tick && (m_count == m_compare);
    n_ctrl  = m_ctrl;
    n_count = m_count;
    n_cmp   = m_compare;
    n_match = m_match;
    n_ps    = (!m_en || tick) ? 16'd0 : m_ps + 16'd1;
    if (tick) n_count = hit ? (m_auto ? 32'd0 : m_count) : m_count + 32'd1;
    if (hit && !m_auto) n_ctrl[0] = 1'b0;
    if (req && we) begin
      case (ra)
        2'd0: begin
          n_ctrl = apply_bytes(n_ctrl, dat_w, sel) & 32'hFFFF_0007;
          n_ps   = 16'd0;
        end
        2'd1: n_count = apply_bytes(m_count, dat_w, sel);
        2'd2: n_cmp   = apply_bytes(m_compare, dat_w, sel);
        default: if (sel[0] && dat_w[0]) n_match = 1'b0;
      endcase
    end
    if (hit) n_match = 1'b1;
    if (req && !we) begin
      m_dat = rdv;
      exp_q.push_back(rdv);
    end
    m_ack_rd  = req & ~we;
    m_ack     = req;
    m_ctrl    = n_ctrl;
    m_count   = n_count;
    m_compare = n_cmp;
    m_match   = n_match;
    m_ps      = n_ps;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- scoreboard ----------------
  initial forever begin
    @(negedge clk);
    check("sb_ack", {31'd0, ack}, {31'd0, m_ack});
    check("sb_irq", {31'd0, irq}, {31'd0, m_match & m_ctrl[2]});
    check("sb_dat_hold", dat_r, m_dat);
    if (m_ack && m_ack_rd && exp_q.size() > 0) check("sb_rd_data", dat_r, exp_q.pop_front());
  end

  // ---------------- driver tasks ----------------
  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [ADR_W-1:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d; sel = s;
    @(posedge clk); #1;
    check("wr_ack", {31'd0, ack}, 32'd1);
    bus_idle();
    @(posedge clk); #1;
    check("wr_ack_drop", {31'd0, ack}, 32'd0);
  endtask

  task automatic wb_read(input logic [ADR_W-1:0] a, output logic [31:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'h0;
    @(posedge clk); #1;
    check("rd_ack", {31'd0, ack}, 32'd1);
    d = dat_r;
    bus_idle();
    @(posedge clk); #1;
  endtask

  task automatic read_expect(input string name, input logic [ADR_W-1:0] a, input logic [31:0] e);
    logic [31:0] v;
    wb_read(a, v);
    check(name, v, e);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic             is_wr;
    logic [ADR_W-1:0] a;
    logic [31:0]      d;
    logic [3:0]       s;
    logic [31:0]      exp;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [ADR_W-1:0] a,
                              input logic [31:0] d, input logic [3:0] s,
                              input logic [31:0] e);
    vec_t v;
    v.is_wr = w; v.a = a; v.d = d; v.s = s; v.exp = e;
    return v;
  endfunction

  vec_t vecs[19];

  // ---------------- main test ----------------
  initial begin
    logic [31:0] v;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; sel = 4'h0; dat_w = 32'd0;

    vecs[0]  = mk(1'b0, 30'd0,          32'd0,          4'h0, 32'd0);
    vecs[1]  = mk(1'b0, 30'd1,          32'd0,          4'h0, 32'd0);
    vecs[2]  = mk(1'b0, 30'd2,          32'd0,          4'h0, 32'd0);
    vecs[3]  = mk(1'b0, 30'd3,          32'd0,          4'h0, 32'd0);
    vecs[4]  = mk(1'b1, 30'd2,          32'h0000_0005,  4'hF, 32'd0);
    vecs[5]  = mk(1'b0, 30'd2,          32'd0,          4'h0, 32'h0000_0005);
    vecs[6]  = mk(1'b1, 30'd2,          32'h1122_3344,  4'hF, 32'd0);
    vecs[7]  = mk(1'b1, 30'd2,          32'hAABB_CCDD,  4'h6, 32'd0);
    vecs[8]  = mk(1'b0, 30'd2,          32'd0,          4'h0, 32'h11BB_CC44);
    vecs[9]  = mk(1'b1, 30'd0,          32'hFFFF_FFF8,  4'hF, 32'd0);
    vecs[10] = mk(1'b0, 30'd0,          32'd0,          4'h0, 32'hFFFF_0000);
    vecs[11] = mk(1'b1, 30'd0,          32'h0000_0006,  4'h1, 32'd0);
    vecs[12] = mk(1'b0, 30'd0,          32'd0,          4'h0, 32'hFFFF_0006);
    vecs[13] = mk(1'b1, 30'd0,          32'd0,          4'hF, 32'd0);
    vecs[14] = mk(1'b0, 30'd3,          32'd0,          4'h0, 32'd0);
    vecs[15] = mk(1'b1, 30'h3FFF_FFF5,  32'hCAFE_F00D,  4'hF, 32'd0);
    vecs[16] = mk(1'b0, 30'h0000_0009,  32'd0,          4'h0, 32'hCAFE_F00D);
    vecs[17] = mk(1'b1, 30'd1,          32'd0,          4'hF, 32'd0);
    vecs[18] = mk(1'b0, 30'd1,          32'd0,          4'h0, 32'd0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", dat_r, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;

    // Register access table
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].is_wr) wb_write(vecs[i].a, vecs[i].d, vecs[i].s);
      else read_expect($sformatf("vec%0d", i), vecs[i].a, vecs[i].exp);
    end

    // One-shot compare match with interrupt
    wb_write(30'd2, 32'd3, 4'hF);
    wb_write(30'd0, 32'h0000_0005, 4'hF);
    read_expect("oneshot_cnt1", 30'd1, 32'd1);
    read_expect("oneshot_cnt3", 30'd1, 32'd3);
    check("oneshot_irq", {31'd0, irq}, 32'd1);
    read_expect("oneshot_ctrl", 30'd0, 32'h0000_0004);
    read_expect("oneshot_status", 30'd3, 32'd1);
    read_expect("oneshot_hold", 30'd1, 32'd3);
    wb_write(30'd3, 32'd1, 4'h1);
    check("oneshot_irq_clr", {31'd0, irq}, 32'd0);
    wb_write(30'd0, 32'd0, 4'hF);

    // Auto-reload with prescale 2, clear races against match
    wb_write(30'd2, 32'd1, 4'hF);
    wb_write(30'd1, 32'd0, 4'hF);
    wb_write(30'd0, 32'h0002_0003, 4'hF);
    read_expect("reload_cnt_a", 30'd1, 32'd0);
    read_expect("reload_cnt_b", 30'd1, 32'd1);
    read_expect("reload_cnt_c", 30'd1, 32'd1);
    read_expect("reload_match", 30'd3, 32'd1);
    wb_write(30'd3, 32'd1, 4'h1);
    read_expect("reload_cleared", 30'd3, 32'd0);
    read_expect("reload_cnt_d", 30'd1, 32'd0);
    read_expect("reload_match2", 30'd3, 32'd1);
    wb_write(30'd3, 32'd1, 4'h1);
    read_expect("reload_clr_lost", 30'd3, 32'd1);
    wb_write(30'd0, 32'd0, 4'hF);
    wb_write(30'd3, 32'd1, 4'h1);
    read_expect("reload_final", 30'd3, 32'd0);

    // Counter wrap without match
    wb_write(30'd1, 32'hFFFF_FFFF, 4'hF);
    wb_write(30'd2, 32'h0000_0010, 4'hF);
    wb_write(30'd0, 32'h0000_0001, 4'hF);
    read_expect("wrap_cnt", 30'd1, 32'd0);
    read_expect("wrap_nomatch", 30'd3, 32'd0);
    wb_write(30'd0, 32'd0, 4'hF);

    // Reset on the edge that would acknowledge a write
    wb_write(30'd2, 32'd7, 4'hF);
    read_expect("pre_rst_cmp", 30'd2, 32'd7);
    @(negedge clk);
    rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b1;
    adr = 30'd2; dat_w = 32'h0000_DEAD; sel = 4'hF;
    @(posedge clk); #1;
    check("midrst_ack", {31'd0, ack}, 32'd0);
    check("midrst_dat", dat_r, 32'd0);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    bus_idle();
    rst = 1'b0;
    read_expect("midrst_cmp", 30'd2, 32'd0);
    read_expect("midrst_ctrl", 30'd0, 32'd0);

    // Randomized bus traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 299) == 0);
      cyc   = ($urandom_range(0, 3) != 0);
      stb   = ($urandom_range(0, 2) != 0);
      we    = $urandom_range(0, 1) == 1;
      adr   = ADR_W'($urandom);
      sel   = 4'($urandom_range(0, 15));
      case (adr[1:0])
        2'd0:    dat_w = {14'd0, 2'($urandom_range(0, 3)), 16'($urandom)};
        2'd1:    dat_w = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                     : 32'($urandom_range(0, 15));
        2'd2:    dat_w = 32'($urandom_range(0, 12));
        default: dat_w = $urandom;
      endcase
    end
    @(negedge clk);
    rst = 1'b0;
    bus_idle();
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_timer.md
WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 Parameter: ADR_W, default 30, width of Wishbone word address adr_i.
REQ-002 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-high.
REQ-004 cyc_i  input  1  Wishbone cycle valid.
REQ-005 stb_i  input  1  Wishbone strobe; transfer requested when cyc_i & stb_i.
REQ-006 we_i  input  1  1 = write, 0 = read.
REQ-007 adr_i  input  ADR_W  word address; only adr_i[1:0] decoded, upper bits ignored.
REQ-008 sel_i  input  4  byte enables; sel_i[n] gates dat_i[8n+7:8n] on writes.
REQ-009 dat_i  input  32  write data from initiator.
REQ-010 ack_o  output  1  transfer acknowledge, registered.
REQ-011 dat_o  output  32  read data, registered, valid while ack_o = 1.
REQ-012 irq_o  output  1  level interrupt, high while STATUS.MATCH = 1 and CTRL.IRQ_EN = 1.

Function
REQ-013 Register map by adr_i[1:0]: 0 CTRL, 1 COUNT, 2 COMPARE, 3 STATUS.
REQ-014 CTRL bits: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN, [31:16] PRESCALE; bits [15:3] read 0, writes ignored.
REQ-015 STATUS bits: [0] MATCH; all others read 0; writing 1 to bit 0 (with sel_i[0]) clears MATCH, writing 0 has no effect.
REQ-016 Handshake: on an edge where cyc_i & stb_i & ~ack_o, ack_o is set to 1 for exactly one cycle; the next edge clears it regardless of stb_i.
REQ-017 Latency: every access acknowledged one clk_i cycle after strobe seen; no wait states, no err/rty.
REQ-018 Held strobe yields ack every other cycle (ack high, ack low, ack high, ...); each ack is one transfer.
REQ-019 Writes take effect on the same edge that sets ack_o; only bytes with sel_i set change.
REQ-020 Reads: dat_o loaded with the addressed register on the edge that sets ack_o; dat_o otherwise holds its last value.
REQ-021 Strobe with cyc_i = 0 is ignored; deasserting cyc_i while ack_o = 1 does not cancel the already-performed access.
REQ-022 Prescaler: 16-bit counter PS; while EN = 1, PS increments each cycle; when PS = PRESCALE, a tick occurs and PS <= 0.
REQ-023 PRESCALE = 0 gives a tick every cycle; PRESCALE = N gives a tick every N+1 cycles.
REQ-024 PS <= 0 whenever EN = 0 or on any CTRL write.
REQ-025 On tick: if COUNT = COMPARE then MATCH <= 1 and COUNT <= 0 when AUTO_RELOAD = 1, else COUNT holds and EN <= 0; otherwise COUNT <= COUNT + 1.
REQ-026 COUNT wraps 0xFFFFFFFF -> 0x00000000 modulo 2^32 without setting MATCH.
REQ-027 Bus write to COUNT on a tick edge: bus value wins, tick increment/reload discarded for that edge.
REQ-028 Bus write to CTRL on a tick edge that also clears EN (non-reload match): bus-written EN wins.
REQ-029 MATCH set and STATUS clear on the same edge: MATCH stays 1.
REQ-030 irq_o is combinational from registered MATCH and IRQ_EN; no other glitch sources.

Reset
REQ-031 When rst_i = 1 at an edge: ack_o = 0, dat_o = 0, CTRL = 0, COUNT = 0, COMPARE = 0, MATCH = 0, PS = 0; hence irq_o = 0.
REQ-032 Reset mid-transfer: pending transfer is dropped, no ack issued for it, register write on that edge not performed.
REQ-033 First access accepted on the first edge after rst_i falls.

Verification
REQ-034 Write COMPARE = 0x00000005 sel 0xF, read back -> ack_o exactly one cycle after strobe, dat_o = 0x00000005.
REQ-035 Byte write: COMPARE = 0x11223344 then write 0xAABBCCDD sel 0x6 -> readback 0x11BBCC44.
REQ-036 COMPARE = 3, CTRL = 0x00000005 (EN, IRQ_EN, PRESCALE 0) -> COUNT 0,1,2,3 per cycle, MATCH = 1, irq_o = 1, EN reads 0, COUNT holds 3.
REQ-037 CTRL = 0x00020003 (PRESCALE 2, auto-reload), COMPARE = 1 -> COUNT changes every 3 cycles: 0,1,0,1...; MATCH set on each match; STATUS write 0x1 clears MATCH except on a match edge.
REQ-038 COUNT = 0xFFFFFFFF, COMPARE = 0x10, EN = 1 -> COUNT = 0 next tick, MATCH stays 0.
REQ-039 Assert rst_i on the edge where ack would be set for a write to COMPARE -> ack_o = 0, COMPARE = 0, all outputs at reset values.
